poly_note_ctrl: RTL and testbench

POLY_NOTE_CTRL -- requirements
Module: poly_note_ctrl

---
 rtl/poly_pkg.sv | 15 +
 rtl/voice_alloc.sv | 93 +++++++++
 rtl/poly_note_ctrl.sv | 169 ++++++++++++++++
 tb/tb_poly_note_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polyphonic note controller.
// Holds the protocol opcode bytes and the command-parser FSM state type.
package poly_pkg;

   localparam logic [7:0] OP_NOTE_ON  = 8'h90;
   localparam logic [7:0] OP_NOTE_OFF = 8'h80;
   localparam logic [7:0] OP_ALL_OFF  = 8'hFF;

   typedef enum logic [1:0] {
      StIdle,
      StWaitData,
      StApply
   } state_t;

endpackage

// File: rtl/voice_alloc.sv
// Voice table with note allocation, release and round-robin stealing.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   apply         one-cycle strobe: execute op with note this cycle
//   op            latched opcode byte (NOTE_ON / NOTE_OFF / ALL_OFF)
//   note          note code for NOTE_ON / NOTE_OFF
//   voice_note    per-voice note, voice i at [i*NOTE_W +: NOTE_W]
//   voice_active  voice i holds a nonzero note
module voice_alloc
   import poly_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned NOTE_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         apply,
   input  logic [7:0]                   op,
   input  logic [NOTE_W-1:0]            note,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_active
);

   localparam int unsigned PTR_W = $clog2(NUM_VOICES);

   logic [NOTE_W-1:0] note_q [NUM_VOICES];
   logic [NOTE_W-1:0] note_d [NUM_VOICES];
   logic [PTR_W-1:0]  steal_q, steal_d;
   logic              hit;
   logic              free_found;
   logic [PTR_W-1:0]  free_idx;

   // Duplicate detection and lowest-index free voice search.
   always_comb begin
      hit        = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (note_q[i] == note) hit = 1'b1;
         if (!free_found && note_q[i] == '0) begin
            free_found = 1'b1;
            free_idx   = PTR_W'(i);
         end
      end
   end

   always_comb begin
      note_d  = note_q;
      steal_d = steal_q;
      if (apply) begin
         case (op)
            OP_NOTE_ON: begin
               // Note 0 means silence; a note already sounding is not doubled.
               if (note != '0 && !hit) begin
                  if (free_found) begin
                     note_d[free_idx] = note;
                  end else begin
                     note_d[steal_q] = note;
                     steal_d = (steal_q == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_q + PTR_W'(1);
                  end
               end
            end
            OP_NOTE_OFF: begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (note_q[i] == note) note_d[i] = '0;
               end
            end
            OP_ALL_OFF: begin
               for (int i = 0; i < NUM_VOICES; i++) note_d[i] = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= '0;
         steal_q <= '0;
      end else begin
         note_q  <= note_d;
         steal_q <= steal_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
         voice_active[i]                = |note_q[i];
      end
   end

endmodule

// File: rtl/poly_note_ctrl.sv
// Polyphonic note controller: parses UART command bytes, drives a voice
// table and mixes the per-voice square waves into one 1-bit audio stream.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   d_in, rdy     received byte and its available flag (held until acked)
//   ack           one-cycle byte-consumed pulse
//   voice_sout    per-voice square wave from external tone generators
//   voice_note    per-voice note code, voice_active per-voice nonzero flag
//   ain           mixed 1-bit audio; gain, shutdown_l amplifier controls
//   cmd_err       one-cycle protocol error pulse
module poly_note_ctrl
   import poly_pkg::*;
#(
   parameter int unsigned NUM_VOICES  = 4,
   parameter int unsigned NOTE_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   d_in,
   input  logic                         rdy,
   output logic                         ack,
   input  logic [NUM_VOICES-1:0]        voice_sout,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic                         ain,
   output logic                         gain,
   output logic                         shutdown_l,
   output logic                         cmd_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned AW    = $clog2(NUM_VOICES) + 1;
   localparam int unsigned SW    = AW + 1;

   state_t            state_q, state_d;
   logic [7:0]        op_q, op_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_q, err_q, err_d;
   logic              accept, is_data, is_sel, is_all;
   logic [AW-1:0]     acc_q, acc_d;
   logic [SW-1:0]     pop, sum;
   logic              ain_q, ain_d, gain_q;

   // A byte is taken only when not already acking it and not mid-apply.
   assign accept  = rdy && !ack_q && (state_q != StApply);
   assign is_data = !d_in[7];
   assign is_sel  = (d_in == OP_NOTE_ON) || (d_in == OP_NOTE_OFF);
   assign is_all  = (d_in == OP_ALL_OFF);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      note_d  = note_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_sel) begin
                  op_d    = d_in;
                  cnt_d   = '0;
                  state_d = StWaitData;
               end else if (is_all) begin
                  op_d    = OP_ALL_OFF;
                  state_d = StApply;
               end else if (!is_data) begin
                  err_d = 1'b1;
               end
            end
         end
         StWaitData: begin
            if (accept) begin
               if (is_data) begin
                  note_d  = NOTE_W'(d_in[6:0]);
                  state_d = StApply;
               end else if (is_sel) begin
                  op_d  = d_in;
                  cnt_d = '0;
               end else if (is_all) begin
                  op_d    = OP_ALL_OFF;
                  state_d = StApply;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StApply: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         note_q  <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         note_q  <= note_d;
         cnt_q   <= cnt_d;
         ack_q   <= accept;
         err_q   <= err_d;
      end
   end

   voice_alloc #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_W     (NOTE_W)
   ) u_voice_alloc (
      .clk          (clk),
      .rst_n        (rst_n),
      .apply        (state_q == StApply),
      .op           (op_q),
      .note         (note_q),
      .voice_note   (voice_note),
      .voice_active (voice_active)
   );

   // First-order delta-sigma style mixer: emits a 1 each time the running
   // count of high active voices wraps past NUM_VOICES.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         pop = pop + SW'(voice_sout[i] & voice_active[i]);
      end
      sum = SW'(acc_q) + pop;
      if (voice_active == '0) begin
         ain_d = 1'b0;
         acc_d = '0;
      end else if (sum >= SW'(NUM_VOICES)) begin
         ain_d = 1'b1;
         acc_d = AW'(sum - SW'(NUM_VOICES));
      end else begin
         ain_d = 1'b0;
         acc_d = AW'(sum);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         ain_q  <= 1'b0;
         gain_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         ain_q  <= ain_d;
         gain_q <= 1'b1;
      end
   end

   assign ack        = ack_q;
   assign cmd_err    = err_q;
   assign ain        = ain_q;
   assign gain       = gain_q;
   assign shutdown_l = gain_q;

endmodule

// File: tb/tb_poly_note_ctrl.sv
// Self-checking bench for poly_note_ctrl against a behavioural voice model.
module tb_poly_note_ctrl;

   localparam int N  = 4;
   localparam int NW = 8;
   localparam int TO = 20;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [7:0]     d_in = 8'h00;
   logic           rdy = 1'b0;
   logic           ack;
   logic [N-1:0]   voice_sout = '0;
   logic [N*NW-1:0] voice_note;
   logic [N-1:0]   voice_active;
   logic           ain, gain, shutdown_l, cmd_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: list of notes per voice plus steal pointer.
   int mv[N];
   int msteal;

   poly_note_ctrl #(
      .NUM_VOICES  (N),
      .NOTE_W      (NW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d_in         (d_in),
      .rdy          (rdy),
      .ack          (ack),
      .voice_sout   (voice_sout),
      .voice_note   (voice_note),
      .voice_active (voice_active),
      .ain          (ain),
      .gain         (gain),
      .shutdown_l   (shutdown_l),
      .cmd_err      (cmd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic void model_reset();
      for (int i = 0; i < N; i++) mv[i] = 0;
      msteal = 0;
   endfunction

   function automatic void model_on(input int n);
      if (n == 0) return;
      for (int i = 0; i < N; i++) if (mv[i] == n) return;
      for (int i = 0; i < N; i++) begin
         if (mv[i] == 0) begin
            mv[i] = n;
            return;
         end
      end
      mv[msteal] = n;
      msteal = (msteal + 1) % N;
   endfunction

   function automatic void model_off(input int n);
      for (int i = 0; i < N; i++) if (mv[i] == n) mv[i] = 0;
   endfunction

   function automatic void model_all();
      for (int i = 0; i < N; i++) mv[i] = 0;
   endfunction

   function automatic logic [N*NW-1:0] model_notes();
      logic [N*NW-1:0] v;
      for (int i = 0; i < N; i++) v[i*NW +: NW] = NW'(mv[i]);
      return v;
   endfunction

   function automatic logic [N-1:0] model_active();
      logic [N-1:0] a;
      for (int i = 0; i < N; i++) a[i] = (mv[i] != 0);
      return a;
   endfunction

   task automatic check_voices(input string name);
      logic [N*NW-1:0] en;
      logic [N-1:0]    ea;
      en = model_notes();
      ea = model_active();
      n_tests++;
      if (voice_note !== en) begin
         n_fail++;
         $display("FAIL %s voice_note: got %h expected %h", name, voice_note, en);
      end
      n_tests++;
      if (voice_active !== ea) begin
         n_fail++;
         $display("FAIL %s voice_active: got %b expected %b", name, voice_active, ea);
      end
   endtask

   // Present one byte, hold until acked, return one cycle after the ack.
   task automatic send_byte(input logic [7:0] b, output bit err);
      bit got;
      got = 0;
      err = 0;
      rdy  = 1'b1;
      d_in = b;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (ack === 1'b1) begin
            got = 1;
            err = cmd_err;
            break;
         end
      end
      rdy = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL ack_wait byte %h: got no ack, expected ack within 50 cycles", b);
      end
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_width byte %h: got ack=%b expected 0", b, ack);
      end
   endtask

   task automatic expect_err(input string name, input bit got, input bit exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cmd_err: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic note_cmd(input logic [7:0] op, input int n, input string name);
      bit e1, e2;
      send_byte(op, e1);
      send_byte(8'(n), e2);
      if (op == 8'h90) model_on(n);
      else model_off(n);
      expect_err(name, e1 | e2, 1'b0);
      check_voices(name);
   endtask

   task automatic all_off(input string name);
      bit e;
      send_byte(8'hFF, e);
      model_all();
      expect_err(name, e, 1'b0);
      check_voices(name);
   endtask

   task automatic test_reset();
      voice_sout = '0;
      rdy = 1'b0;
      model_reset();
      #12;
      check_voices("reset");
      n_tests++;
      if ({ack, cmd_err, ain, gain, shutdown_l} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outs: got %b expected 00000", {ack, cmd_err, ain, gain, shutdown_l});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({gain, shutdown_l, ack, cmd_err, ain} !== 5'b11000) begin
         n_fail++;
         $display("FAIL post_reset_outs: got %b expected 11000",
                  {gain, shutdown_l, ack, cmd_err, ain});
      end
   endtask

   task automatic test_single_note();
      bit e;
      send_byte(8'h90, e);
      rdy  = 1'b1;
      d_in = 8'h3C;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (ack === 1'b1) break;
      end
      rdy = 1'b0;
      n_tests++;
      if (voice_active !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_latency: got %b expected 0000 at ack cycle", voice_active);
      end
      @(negedge clk);
      model_on(8'h3C);
      check_voices("single_note");
      n_tests++;
      if (voice_active !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_active: got %b expected 0001", voice_active);
      end
   endtask

   task automatic test_steal();
      int notes[5] = '{8'h3C, 8'h40, 8'h43, 8'h48, 8'h4C};
      all_off("steal_clear");
      foreach (notes[i]) note_cmd(8'h90, notes[i], "steal_fill");
      n_tests++;
      if (voice_note !== 32'h4843404C) begin
         n_fail++;
         $display("FAIL steal_fifth: got %h expected 4843404c", voice_note);
      end
      note_cmd(8'h90, 8'h50, "steal_next");
      n_tests++;
      if (voice_note[15:8] !== 8'h50) begin
         n_fail++;
         $display("FAIL steal_ptr_one: got %h expected 50 in voice 1", voice_note[15:8]);
      end
   endtask

   task automatic test_dup_off();
      all_off("dup_clear");
      voice_sout = '1;
      note_cmd(8'h90, 8'h3C, "dup_on1");
      note_cmd(8'h90, 8'h3C, "dup_on2");
      n_tests++;
      if (voice_active !== 4'b0001) begin
         n_fail++;
         $display("FAIL dup_single: got %b expected 0001", voice_active);
      end
      note_cmd(8'h80, 8'h3C, "dup_off");
      @(negedge clk);
      n_tests++;
      if (ain !== 1'b0) begin
         n_fail++;
         $display("FAIL dup_ain: got %b expected 0", ain);
      end
      voice_sout = '0;
      note_cmd(8'h80, 8'h22, "off_absent");
   endtask

   task automatic test_timeout();
      bit e;
      int k;
      all_off("to_clear");
      note_cmd(8'h90, 8'h30, "to_seed");
      send_byte(8'h90, e);
      k = -1;
      for (int c = 1; c <= TO + 5; c++) begin
         @(negedge clk);
         if (cmd_err === 1'b1) begin
            k = c;
            break;
         end
      end
      n_tests++;
      if (k != TO - 1) begin
         n_fail++;
         $display("FAIL timeout_cycle: got %0d expected %0d", k, TO - 1);
      end
      @(negedge clk);
      n_tests++;
      if (cmd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: got %b expected 0", cmd_err);
      end
      check_voices("timeout_voices");
      send_byte(8'h3C, e);
      expect_err("stray_after_to", e, 1'b0);
      check_voices("stray_after_to");
      send_byte(8'hA5, e);
      expect_err("bad_idle", e, 1'b1);
      send_byte(8'h90, e);
      send_byte(8'hA5, e);
      expect_err("bad_wait", e, 1'b1);
      send_byte(8'h41, e);
      expect_err("stray_after_bad", e, 1'b0);
      check_voices("stray_after_bad");
   endtask

   task automatic test_mixer_directed();
      int ones;
      all_off("mix_clear");
      voice_sout = '1;
      ones = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ain === 1'b1) ones++;
      end
      n_tests++;
      if (ones != 0) begin
         n_fail++;
         $display("FAIL mix_silent: got %0d ones expected 0", ones);
      end
      voice_sout = '0;
      all_off("mix_clear2");
      note_cmd(8'h90, 8'h3C, "mix_v0");
      note_cmd(8'h90, 8'h40, "mix_v1");
      voice_sout = '1;
      ones = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ain === 1'b1) ones++;
      end
      n_tests++;
      if (ones != 4) begin
         n_fail++;
         $display("FAIL mix_duty: got %0d ones expected 4", ones);
      end
      all_off("mix_alloff");
      voice_sout = '0;
      @(negedge clk);
   endtask

   task automatic test_mixer_random();
      int acc, s, nv;
      logic [N-1:0] act, sv;
      bit exp_ain;
      for (int r = 0; r < 4; r++) begin
         voice_sout = '0;
         all_off("mixr_clear");
         nv = $urandom_range(1, N);
         for (int v = 0; v < nv; v++) note_cmd(8'h90, 10 + 10 * v + r, "mixr_load");
         act = model_active();
         acc = 0;
         exp_ain = 0;
         for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c > 0) begin
               n_tests++;
               if (ain !== exp_ain) begin
                  n_fail++;
                  $display("FAIL mixr_ain round %0d cycle %0d: got %b expected %b",
                           r, c, ain, exp_ain);
               end
            end
            sv = N'($urandom);
            voice_sout = sv;
            s = 0;
            for (int i = 0; i < N; i++) s += (sv[i] & act[i]);
            if (acc + s >= N) begin
               exp_ain = 1;
               acc = acc + s - N;
            end else begin
               exp_ain = 0;
               acc = acc + s;
            end
         end
      end
      voice_sout = '0;
      all_off("mixr_end");
   endtask

   task automatic test_random_cmds();
      bit e1, e2, e3;
      int n, kind;
      for (int t = 0; t < 50; t++) begin
         kind = $urandom_range(0, 9);
         n = $urandom_range(0, 9);
         if (kind <= 4) begin
            note_cmd(8'h90, n, "rand_on");
         end else if (kind <= 6) begin
            note_cmd(8'h80, n, "rand_off");
         end else if (kind == 7) begin
            all_off("rand_all");
         end else if (kind == 8) begin
            // Second opcode replaces the pending one.
            send_byte(8'h90, e1);
            send_byte(8'h80, e2);
            send_byte(8'(n), e3);
            model_off(n);
            expect_err("rand_replace", e1 | e2 | e3, 1'b0);
            check_voices("rand_replace");
         end else begin
            send_byte(8'(n + 8'h20), e1);
            expect_err("rand_stray", e1, 1'b0);
            check_voices("rand_stray");
         end
      end
   endtask

   task automatic test_reset_mid();
      bit e;
      note_cmd(8'h90, 8'h55, "mid_seed");
      send_byte(8'h90, e);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_voices("mid_reset");
      n_tests++;
      if ({ack, cmd_err, ain, gain, shutdown_l} !== 5'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outs: got %b expected 00000",
                  {ack, cmd_err, ain, gain, shutdown_l});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h3C, e);
      expect_err("mid_stray", e, 1'b0);
      check_voices("mid_stray");
      for (int v = 0; v < 5; v++) note_cmd(8'h90, 8'h60 + v, "mid_refill");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_note();
      test_steal();
      test_dup_off();
      test_timeout();
      test_mixer_directed();
      test_mixer_random();
      test_random_cmds();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
